// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, runs a req/ack read to instruction memory,
// latches the returned word and commits the sequential or branch-target PC on write-back.
module fetch_unit #(
  parameter int                  PC_WIDTH    = 64,
  parameter int                  INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   fetch_start,
  input  logic                   pc_update,
  input  logic                   branch,
  input  logic                   zero,
  input  logic [PC_WIDTH-1:0]    branch_offset,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [PC_WIDTH-1:0]    pc,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   instr_valid,
  output logic                   busy,
  output logic                   misaligned,
  output logic [31:0]            retired
);

  typedef enum logic [1:0] {IDLE, REQ, VALID, HALT} state_t;
  state_t state;

  logic [PC_WIDTH-1:0] next_pc;

  // Offset add wraps modulo 2^PC_WIDTH by construction.
  assign next_pc   = (branch & zero) ? pc + branch_offset : pc + PC_WIDTH'(4);
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instruction <= '0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      busy        <= 1'b0;
      misaligned  <= 1'b0;
      retired     <= '0;
    end else if (enable) begin
      case (state)
        IDLE: if (fetch_start) begin
          state    <= REQ;
          imem_req <= 1'b1;
          busy     <= 1'b1;
        end
        REQ: if (imem_ack) begin
          state       <= VALID;
          instruction <= imem_rdata;
          instr_valid <= 1'b1;
          imem_req    <= 1'b0;
          busy        <= 1'b0;
        end
        VALID: if (pc_update) begin
          instr_valid <= 1'b0;
          if (next_pc[1:0] == 2'b00) begin
            state   <= IDLE;
            pc      <= next_pc;
            retired <= retired + 32'd1;
          end else begin
            // Unaligned target: keep the old pc and park until reset.
            state      <= HALT;
            misaligned <= 1'b1;
          end
        end
        HALT: state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: fetch handshake, wait states, PC update paths,
// freeze, wrap, mid-request reset and the misaligned halt.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, enable, fetch_start, pc_update, branch, zero;
  logic [63:0] branch_offset;
  logic        imem_req, imem_ack;
  logic [63:0] imem_addr, pc;
  logic [31:0] imem_rdata, instruction, retired;
  logic        instr_valid, busy, misaligned;

  int          passed = 0;
  int          total  = 0;
  logic [63:0] exp_pc;
  logic [31:0] exp_ret;
  logic [31:0] last_instr;

  fetch_unit #(.PC_WIDTH(64), .INSTR_WIDTH(32), .RESET_PC(64'h0)) dut (
    .clk(clk), .reset(reset), .enable(enable), .fetch_start(fetch_start),
    .pc_update(pc_update), .branch(branch), .zero(zero), .branch_offset(branch_offset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .pc(pc), .instruction(instruction),
    .instr_valid(instr_valid), .busy(busy), .misaligned(misaligned), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic fetch(input logic [31:0] data, input int waits);
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    chk("req_on", {63'd0, imem_req}, 64'd1);
    chk("busy_on", {63'd0, busy}, 64'd1);
    chk("addr", imem_addr, exp_pc);
    for (int i = 0; i < waits; i++) begin
      step();
      chk("req_hold", {63'd0, imem_req}, 64'd1);
      chk("busy_hold", {63'd0, busy}, 64'd1);
      chk("addr_hold", imem_addr, exp_pc);
    end
    imem_ack   = 1'b1;
    imem_rdata = data;
    step();
    imem_ack   = 1'b0;
    chk("instr", {32'd0, instruction}, {32'd0, data});
    chk("valid", {63'd0, instr_valid}, 64'd1);
    chk("req_off", {63'd0, imem_req}, 64'd0);
    chk("busy_off", {63'd0, busy}, 64'd0);
    last_instr = data;
  endtask

  task automatic update(input logic br, input logic z, input logic [63:0] off,
                        input logic [63:0] nxt);
    pc_update     = 1'b1;
    branch        = br;
    zero          = z;
    branch_offset = off;
    step();
    pc_update     = 1'b0;
    exp_ret       = exp_ret + 32'd1;
    exp_pc        = nxt;
    chk("upd_pc", pc, nxt);
    chk("upd_valid", {63'd0, instr_valid}, 64'd0);
    chk("upd_retired", {32'd0, retired}, {32'd0, exp_ret});
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; fetch_start = 1'b0; pc_update = 1'b0;
    branch = 1'b0; zero = 1'b0; branch_offset = '0; imem_ack = 1'b0; imem_rdata = '0;
    exp_pc = 64'h0; exp_ret = 32'd0; last_instr = 32'd0;
    step(); step();
    reset = 1'b0;
    chk("rst_pc", pc, 64'h0);
    chk("rst_req", {63'd0, imem_req}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_valid", {63'd0, instr_valid}, 64'd0);
    chk("rst_instr", {32'd0, instruction}, 64'd0);
    chk("rst_mis", {63'd0, misaligned}, 64'd0);
    chk("rst_retired", {32'd0, retired}, 64'd0);

    fetch(32'h00500093, 0);
    update(1'b0, 1'b0, 64'h0, 64'h4);

    // Stray ack and pc_update while idle must do nothing.
    imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF; pc_update = 1'b1;
    step();
    imem_ack = 1'b0; pc_update = 1'b0;
    chk("stray_instr", {32'd0, instruction}, 64'h00500093);
    chk("stray_valid", {63'd0, instr_valid}, 64'd0);
    chk("stray_req", {63'd0, imem_req}, 64'd0);
    chk("stray_pc", pc, 64'h4);
    chk("stray_ret", {32'd0, retired}, 64'd1);

    fetch(32'h11111111, 3);
    update(1'b0, 1'b0, 64'h0, 64'h8);
    fetch(32'h22222222, 1);
    update(1'b0, 1'b1, 64'h40, 64'hC);
    fetch(32'h33333333, 0);
    update(1'b0, 1'b0, 64'h0, 64'h10);
    fetch(32'h44444444, 0);
    update(1'b1, 1'b0, 64'h100, 64'h14);
    fetch(32'h55555555, 2);
    update(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'hC);

    // Freeze mid-request: ack is ignored, request stays up.
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    enable = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hCAFEF00D;
    step();
    chk("frz_instr", {32'd0, instruction}, {32'd0, last_instr});
    chk("frz_valid", {63'd0, instr_valid}, 64'd0);
    chk("frz_req", {63'd0, imem_req}, 64'd1);
    chk("frz_busy", {63'd0, busy}, 64'd1);
    enable = 1'b1;
    step();
    imem_ack = 1'b0;
    chk("thaw_instr", {32'd0, instruction}, 64'hCAFEF00D);
    chk("thaw_valid", {63'd0, instr_valid}, 64'd1);
    chk("thaw_req", {63'd0, imem_req}, 64'd0);

    // 0xC - 16 wraps to the top word, then +4 wraps to zero.
    update(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 64'hFFFF_FFFF_FFFF_FFFC);
    fetch(32'h66666666, 0);
    update(1'b0, 1'b0, 64'h0, 64'h0);
    chk("ret_total", {32'd0, retired}, 64'd8);

    // Reset while a request is outstanding.
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    chk("pre_rst_req", {63'd0, imem_req}, 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_pc = 64'h0; exp_ret = 32'd0;
    chk("midrst_req", {63'd0, imem_req}, 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_pc", pc, 64'h0);
    chk("midrst_ret", {32'd0, retired}, 64'd0);
    chk("midrst_instr", {32'd0, instruction}, 64'd0);

    // Misaligned target from pc 0x20 halts with pc unchanged.
    fetch(32'h77777777, 0);
    update(1'b1, 1'b1, 64'h20, 64'h20);
    fetch(32'h88888888, 0);
    pc_update = 1'b1; branch = 1'b1; zero = 1'b1; branch_offset = 64'h6;
    step();
    pc_update = 1'b0;
    chk("mis_pc", pc, 64'h20);
    chk("mis_flag", {63'd0, misaligned}, 64'd1);
    chk("mis_valid", {63'd0, instr_valid}, 64'd0);
    chk("mis_ret", {32'd0, retired}, 64'd1);
    fetch_start = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h99999999;
    step(); step();
    fetch_start = 1'b0; imem_ack = 1'b0;
    chk("halt_req", {63'd0, imem_req}, 64'd0);
    chk("halt_busy", {63'd0, busy}, 64'd0);
    chk("halt_valid", {63'd0, instr_valid}, 64'd0);
    chk("halt_instr", {32'd0, instruction}, 64'h88888888);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("clr_mis", {63'd0, misaligned}, 64'd0);
    chk("clr_pc", pc, 64'h0);
    chk("clr_ret", {32'd0, retired}, 64'd0);
    chk("clr_instr", {32'd0, instruction}, 64'd0);
    exp_pc = 64'h0;
    fetch(32'hABCD0123, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage for the multicycle 64-bit core, sitting directly upstream of the register file and decode logic. Holds the program counter, issues a request/acknowledge read to instruction memory on each fetch, latches the returned instruction word, and commits the next PC (sequential or taken-branch) when the sequencer signals write-back. Replaces the free-running PC-plus-4 path with a handshaked fetch and branch-aware PC update, and counts retired instructions.

## Interface
- PC_WIDTH, 64, program counter and address width
- INSTR_WIDTH, 32, instruction word width
- RESET_PC, 0, PC value loaded on reset; must be 4-byte aligned
- clk  in  1  core clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- enable  in  1  global run; low freezes all internal state
- fetch_start  in  1  one-cycle pulse from the sequencer in its IF state
- pc_update  in  1  one-cycle pulse from the sequencer in its WB state
- branch  in  1  decoded branch flag for the held instruction
- zero  in  1  ALU zero flag for the held instruction
- branch_offset  in  PC_WIDTH  signed byte offset (sign-extended immediate)
- imem_req  out  1  instruction memory read request
- imem_addr  out  PC_WIDTH  read address, equals pc
- imem_ack  in  1  memory has valid imem_rdata this cycle
- imem_rdata  in  INSTR_WIDTH  instruction word from memory
- pc  out  PC_WIDTH  current program counter
- instruction  out  INSTR_WIDTH  latched instruction word
- instr_valid  out  1  instruction holds a fetched word for the current pc
- busy  out  1  high in REQ state
- misaligned  out  1  sticky: a computed next PC was not 4-byte aligned
- retired  out  32  count of committed pc_update events, wraps at 2^32

## Operation
- States: IDLE, REQ, VALID, HALT. Registered outputs only.
- Reset (sync, active-high, overrides enable): state IDLE, pc = RESET_PC, instruction = 0, instr_valid = 0, imem_req = 0, busy = 0, misaligned = 0, retired = 0.
- enable low: no state, pc, instruction, counter or flag changes; imem_req holds its value (an outstanding request stays asserted); imem_ack is ignored.
- IDLE: fetch_start -> REQ. pc_update ignored.
- REQ: imem_req = 1, busy = 1, imem_addr = pc. On imem_ack: instruction <= imem_rdata, instr_valid <= 1, imem_req <= 0, -> VALID. fetch_start ignored.
- VALID: instruction and instr_valid stable. fetch_start ignored. On pc_update:
  - next = (branch & zero) ? pc + branch_offset : pc + 4, modulo 2^PC_WIDTH (wrap, no flag).
  - next[1:0] == 0: pc <= next, instr_valid <= 0, retired <= retired + 1, -> IDLE.
  - next[1:0] != 0: pc unchanged, misaligned <= 1, instr_valid <= 0, retired unchanged, -> HALT.
- HALT: imem_req = 0; all inputs except reset ignored; exit only via reset.
- imem_ack outside REQ (or with enable low) is ignored; no instruction capture.
- fetch_start and pc_update in the same cycle: only the one legal in the current state acts.

## Timing
- fetch_start sampled at edge E -> imem_req = 1 in the cycle after E.
- imem_ack sampled high at edge A with imem_req = 1 -> instruction, instr_valid = 1, imem_req = 0 in the cycle after A.
- Minimum fetch latency: ack held high -> instr_valid two cycles after the fetch_start cycle.
- pc_update at edge U -> new pc, instr_valid = 0, retired incremented in the cycle after U; next fetch_start accepted from that cycle.
- imem_addr is stable for the whole REQ interval.

## Test plan
- Reset then fetch: RESET_PC = 0, fetch_start, ack on first REQ cycle with rdata 0x00500093 -> imem_req high one cycle, imem_addr 0, instruction 0x00500093, instr_valid high, busy low.
- Wait states: ack delayed 3 cycles -> imem_req and imem_addr = pc stay stable 4 cycles, busy high throughout; stray ack in IDLE causes no capture.
- Sequential and branch: pc 0x10, pc_update with branch 1, zero 0 -> pc 0x14; then branch 1, zero 1, offset -8 -> pc 0x0C; retired increments by 1 each.
- Misaligned target: pc 0x20, branch/zero 1, offset 0x6 -> pc stays 0x20, misaligned 1, state HALT; fetch_start ignored until reset clears all outputs.
- Freeze: enable low during REQ with ack pulsed -> nothing captured, imem_req stays 1; enable high with ack -> capture proceeds normally.
- Wrap and reset mid-op: pc 0xFFFF_FFFF_FFFF_FFFC, pc_update no branch -> pc 0; retired preloaded to 0xFFFF_FFFF wraps to 0; reset asserted in REQ -> next cycle IDLE, imem_req 0, pc = RESET_PC.
